// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and constants for the ADC frame capture block
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int FRAME_CNT_W = 16;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - synchronous show-ahead FIFO; writes while full are dropped
module adc_capture_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Masked when empty so the stream reads zero out of reset, before any write.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - trig-started ADC frame capture into a FIFO, streamed out with a last marker
// Optional ramp test pattern in place of adc_data: ADC_FRAME_CAPTURE_TEST_PATTERN_EN
module adc_frame_capture #(
  parameter int DATA_W     = 14,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              trig,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);
  import adc_capture_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   trig_sync_q, trig_sync_d;
  logic                     trig_prev_q, trig_prev_d;
  logic                     trig_edge;
  logic [CNT_W-1:0]         sample_cnt_q, sample_cnt_d;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                     overflow_q, overflow_d;
  logic                     sample_in, sample_last, frame_start;
  logic                     fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_W-1:0]        cap_data;
  logic [DATA_W:0]          fifo_rdata;

  // Edge detect compares two registered stages, so CAPTURE lands on the third clk edge after trig rises.
  always_comb begin
    trig_sync_d = {trig_sync_q[SYNC_STAGES-2:0], trig};
    trig_prev_d = trig_sync_q[SYNC_STAGES-1];
  end
  assign trig_edge = trig_sync_q[SYNC_STAGES-1] && !trig_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!init_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (trig_edge) state_d = CAPTURE;
        CAPTURE: if (adc_valid && sample_cnt_q == LAST_IDX) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q == CAPTURE);
    sample_in   = busy && adc_valid && init_done;
    sample_last = sample_in && (sample_cnt_q == LAST_IDX);
    frame_start = (state_q == ARMED) && init_done && trig_edge;
    fifo_push   = sample_in;
    fifo_flush  = !init_done;
  end

  // Dropped samples still advance the counter so frame boundaries stay aligned to the ADC.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overflow_d   = overflow_q;
    if (!init_done || frame_start) begin
      sample_cnt_d = '0;
    end else if (sample_in) begin
      sample_cnt_d = sample_last ? '0 : sample_cnt_q + CNT_W'(1);
    end
    if (sample_last)            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    if (sample_in && fifo_full) overflow_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_sync_q  <= '0;
      trig_prev_q  <= 1'b0;
      sample_cnt_q <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      trig_sync_q  <= trig_sync_d;
      trig_prev_q  <= trig_prev_d;
      sample_cnt_q <= sample_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef ADC_FRAME_CAPTURE_TEST_PATTERN_EN
  logic [DATA_W-1:0] ramp_q, ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (!init_done || frame_start) ramp_d = '0;
    else if (sample_in)            ramp_d = ramp_q + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramp_q <= '0;
    else        ramp_q <= ramp_d;
  end

  assign cap_data = ramp_q;
`else
  assign cap_data = adc_data;
`endif

  adc_capture_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({sample_last, cap_data}),
    .pop   (out_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = fifo_rdata[DATA_W];
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - self-checking bench for adc_frame_capture
module tb_adc_frame_capture;

  localparam int DATA_W     = 14;
  localparam int FRAME_LEN  = 256;
  localparam int FIFO_DEPTH = 512;

  logic              clk = 1'b0;
  logic              rst_n, init_done, trig, adc_valid, out_ready;
  logic [DATA_W-1:0] adc_data, out_data;
  logic              out_valid, out_last, busy, overflow;
  logic [15:0]       frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0] exp_q[$];
  bit              exp_ovf    = 1'b0;
  int              exp_frames = 0;
  int              ready_mode = 1;

  typedef struct {
    int base;
    int step;
    int gap;
    int rmode;
    bit retrig;
    int exp_frame_cnt;
    bit exp_overflow;
  } frame_vec_t;

  frame_vec_t vecs[4];

  always #5 clk = ~clk;

  adc_frame_capture #(
    .DATA_W     (DATA_W),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .trig      (trig),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Scoreboard: every presented word must match the oldest expected word; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h expected=none", {out_last, out_data});
        end else begin
          check("stream_word", 32'({out_last, out_data}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_sample(input int idx, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] ed;
`ifdef ADC_FRAME_CAPTURE_TEST_PATTERN_EN
    ed = DATA_W'(idx);
`else
    ed = d;
`endif
    if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
    else                            exp_q.push_back({(idx == FRAME_LEN - 1), ed});
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic arm_trigger();
    trig = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) check("trig_latency_pre", 32'(busy), 32'd0);
    end
    check("trig_latency_busy", 32'(busy), 32'd1);
    trig = 1'b0;
  endtask

  task automatic run_frame(input int base, input int step, input int gap, input bit retrig);
    arm_trigger();
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (gap > 0 && (i % 3) == 0) begin
        for (int g = 0; g < gap; g++) tick();
      end
      if (retrig && i == 50) trig = 1'b1;
      if (retrig && i == 60) trig = 1'b0;
      send_sample(i, DATA_W'(base + i * step));
    end
    exp_frames++;
    check("busy_after_frame", 32'(busy), 32'd0);
    check("frame_cnt_step", 32'(frame_cnt), 32'(exp_frames));
  endtask

  task automatic drain();
    int n;
    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{base: 0,       step: 1, gap: 0, rmode: 1, retrig: 1'b0, exp_frame_cnt: 1, exp_overflow: 1'b0};
    vecs[1] = '{base: 'h3F00,  step: 3, gap: 1, rmode: 2, retrig: 1'b0, exp_frame_cnt: 2, exp_overflow: 1'b0};
    vecs[2] = '{base: 100,     step: 7, gap: 0, rmode: 1, retrig: 1'b1, exp_frame_cnt: 3, exp_overflow: 1'b0};
    vecs[3] = '{base: 'h2000,  step: -1, gap: 2, rmode: 2, retrig: 1'b0, exp_frame_cnt: 4, exp_overflow: 1'b0};

    rst_n     = 1'b0;
    init_done = 1'b0;
    trig      = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Trigger while IDLE must be forgotten once init_done arrives.
    trig = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    trig = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("idle_trig_busy", 32'(busy), 32'd0);
    init_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adc_valid = 1'b1;
      adc_data  = DATA_W'(k);
      tick();
    end
    adc_valid = 1'b0;
    check("idle_trig_no_capture", 32'(busy), 32'd0);
    check("idle_trig_out_valid", 32'(out_valid), 32'd0);
    check("idle_trig_frame_cnt", 32'(frame_cnt), 32'd0);

    foreach (vecs[v]) begin
      ready_mode = vecs[v].rmode;
      run_frame(vecs[v].base, vecs[v].step, vecs[v].gap, vecs[v].retrig);
      for (int k = 0; k < 8; k++) tick();
      check("vec_no_second_frame", 32'(busy), 32'd0);
      drain();
      check("vec_frame_cnt", 32'(frame_cnt), 32'(vecs[v].exp_frame_cnt));
      check("vec_overflow",  32'(overflow),  32'(vecs[v].exp_overflow));
    end

    // Backpressure: three frames into a 512-word FIFO with the sink stalled.
    ready_mode = 0;
    tick();
    for (int f = 0; f < 3; f++) run_frame(f * 'h400, 1, 0, 1'b0);
    check("ovf_flag",      32'(overflow),     32'(exp_ovf));
    check("ovf_flag_set",  32'(exp_ovf),      32'd1);
    check("ovf_retained",  32'(exp_q.size()), 32'(FIFO_DEPTH));
    check("ovf_frame_cnt", 32'(frame_cnt),    32'd7);
    drain();
    check("ovf_sticky",    32'(overflow),     32'd1);

    // init_done drop mid-frame flushes the FIFO and keeps the counters.
    ready_mode = 0;
    tick();
    arm_trigger();
    for (int i = 0; i < 100; i++) send_sample(i, DATA_W'(i + 'h100));
    check("drop_pre_valid", 32'(out_valid), 32'd1);
    init_done = 1'b0;
    tick();
    exp_q.delete();
    check("drop_out_valid", 32'(out_valid), 32'd0);
    check("drop_busy",      32'(busy),      32'd0);
    check("drop_frame_cnt", 32'(frame_cnt), 32'd7);
    check("drop_overflow",  32'(overflow),  32'd1);
    for (int k = 0; k < 4; k++) tick();
    init_done  = 1'b1;
    ready_mode = 1;
    tick();
    tick();
    run_frame(5, 2, 0, 1'b0);
    drain();
    check("rearm_frame_cnt", 32'(frame_cnt), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_frame_capture.md
Name: adc_frame_capture

Overview:
- Sits downstream of the ADC SPI configuration stage and consumes its init-done flag.
- Once ADC configuration is finished, each rising edge of the external trig captures a frame of FRAME_LEN ADC samples into an internal FIFO.
- The frame is presented to the interferometer processing chain as a valid/ready stream with a last marker.
- Reports overflow and frame count for debug.

Parameters:
- DATA_W, 14: ADC sample width.
- FRAME_LEN, 256: samples per frame, minimum 2.
- FIFO_DEPTH, 512: buffer words, power of two.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- init_done  input  1  ADC configuration finished; level, synchronous to clk
- trig  input  1  asynchronous frame trigger
- adc_data  input  DATA_W  ADC sample
- adc_valid  input  1  sample strobe, one cycle per sample
- out_data  output  DATA_W  streamed sample
- out_valid  output  1  out_data valid
- out_last  output  1  final sample of frame, qualified by out_valid
- out_ready  input  1  downstream accept
- busy  output  1  state is CAPTURE
- overflow  output  1  sticky: a sample was dropped
- frame_cnt  output  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, overflow=0, frame_cnt=0, FIFO empty, state IDLE.
- trig path: passes a 2-flop synchronizer, then a registered rising-edge detect. A trig rising edge makes state CAPTURE on the 3rd clk edge after it.
- IDLE: waits for init_done=1, then goes to ARMED next cycle.
- ARMED: on trig edge, goes to CAPTURE; sample counter cleared to 0.
- CAPTURE: each cycle with adc_valid=1 is one sample; sample counter increments. The sample with counter==FRAME_LEN-1 is written with last=1. The state then returns to ARMED and frame_cnt increments in the same cycle.
- Trig edges in IDLE or CAPTURE are ignored and not queued.
- init_done falling in any state:
  - State goes to IDLE next cycle.
  - FIFO is flushed (pointers cleared, out_valid=0 next cycle).
  - Sample counter is cleared; frame_cnt and overflow are kept.
- FIFO:
  - Stores {last, data}, with registered write and show-ahead read.
  - Sample accepted at cycle n on an empty FIFO gives out_valid=1 at cycle n+1.
  - A pop occurs when out_valid&&out_ready.
  - A simultaneous push and pop when full is NOT allowed. Full means the write is dropped, which keeps the logic simple.
- Full while a sample arrives in CAPTURE:
  - The sample is dropped and overflow is set (sticky until reset).
  - The sample counter still advances, so frame timing is preserved.
  - If the dropped sample is the last one, no last-marked word is emitted for that frame. frame_cnt still increments.
- Push and pop in the same cycle when not full: both happen, and the occupancy is unchanged.
- out_data/out_last are stable while out_valid=1 and out_ready=0.
- busy is combinational from state==CAPTURE, glitch-free because state is registered.

Optional Feature:
- Macro: ADC_FRAME_CAPTURE_TEST_PATTERN_EN.
- Defined: the captured value is replaced by a DATA_W ramp. The ramp resets to 0 at each frame start and increments per accepted adc_valid, so the frame reads 0..FRAME_LEN-1 truncated to DATA_W.
- Undefined: adc_data is captured unchanged and no ramp logic exists.

Decomposition:
- Package adc_capture_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE}
  - FRAME_CNT_W=16
  - the sync stage count constant (2)
- One sub-module: adc_capture_fifo, a synchronous show-ahead FIFO. It has parameters DATA_W+1 and FIFO_DEPTH, ports push/pop/full/empty/flush.
- The FSM, trig sync and counters stay in the top module.

Test Plan:
- Reset then init_done=1, trig pulse, 256 adc_valid with data 0..255, out_ready=1. Expect 256 words 0..255 in order, out_last only on 255, frame_cnt=1, overflow=0.
- Trig edge in IDLE (init_done=0), then init_done=1 with no new trig. Expect no capture and busy=0.
- Second trig during CAPTURE. Expect it ignored; exactly one frame and frame_cnt=1.
- out_ready=0 with FIFO_DEPTH=512, three frames (768 samples). Expect overflow=1 after sample 512 and 512 words retained. Frame 2's last is dropped, yet frame_cnt=3.
- init_done deasserted mid-frame after 100 samples. Expect out_valid=0 next cycle, state IDLE, frame_cnt unchanged. After re-arm and trig, a full clean frame follows.
- With ADC_FRAME_CAPTURE_TEST_PATTERN_EN and adc_data tied to 0x3FFF: expect out_data 0..255.
